// File: rtl/seg_scan_driver.sv
// Two-digit BCD display scanner: latches the product digits on ld and
// time-multiplexes them onto a shared active-low 7-segment bus.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] ten,
  input  logic [3:0] one,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       scan_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;
  localparam logic [3:0]       AN_OFF   = 4'hF;
  localparam logic [3:0]       AN_ONES  = 4'b1110;
  localparam logic [3:0]       AN_TENS  = 4'b1101;

  logic [CNT_W-1:0] cnt;
  logic             sel;
  logic [3:0]       hold_ten;
  logic [3:0]       hold_one;
  logic             wrap_c;
  logic [6:0]       seg_nxt;
  logic [3:0]       an_nxt;

  // BCD to active-low {g..a}; non-BCD codes show a dash
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign wrap_c = (cnt == CNT_LAST);

  // Free-running prescaler; each wrap advances the digit select and pulses scan_tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sel       <= 1'b0;
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= wrap_c;
      if (wrap_c) begin
        cnt <= '0;
        sel <= ~sel;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Digit holding registers, reloaded on every cycle ld is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_ten <= 4'd0;
      hold_one <= 4'd0;
    end else if (ld) begin
      hold_ten <= ten;
      hold_one <= one;
    end
  end

  // Select the lit digit and its segment pattern from the current slot
  always_comb begin
    seg_nxt = SEG_OFF;
    an_nxt  = AN_OFF;
    if (!sel) begin
      an_nxt  = AN_ONES;
      seg_nxt = enc(hold_one);
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      if (hold_ten != 4'd0) begin
        an_nxt  = AN_TENS;
        seg_nxt = enc(hold_ten);
      end
`else
      an_nxt  = AN_TENS;
      seg_nxt = enc(hold_ten);
`endif
    end
  end

  // Anodes and cathodes switch on the same edge to avoid ghosting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule
